// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN        register value width
//   REG_ADDR_W  architectural register address width
//   REG_ZERO    hard-wired zero register; writes to it are dropped
//   wb_src_e    identifies which writeback source won arbitration
package rf_wb_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two result sources and the arbiter, plus the
// registered regfile write port the arbiter drives.
//   wb_hold                          pipeline freeze
//   alu_valid/alu_rd/alu_data/alu_ready  source 0 handshake
//   lsu_valid/lsu_rd/lsu_data/lsu_ready  source 1 handshake
//   rf_we/rf_addr_rd/rf_data_rd      regfile write port
// Modports: master = the source side (execute/memory stages), slave = arbiter.
interface rf_wb_arbiter_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
);
   logic              wb_hold;
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              alu_ready;
   logic              lsu_valid;
   logic [ADDR_W-1:0] lsu_rd;
   logic [XLEN-1:0]   lsu_data;
   logic              lsu_ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr_rd;
   logic [XLEN-1:0]   rf_data_rd;

   modport master (
      output wb_hold, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  alu_ready, lsu_ready, rf_we, rf_addr_rd, rf_data_rd
   );

   modport slave (
      input  wb_hold, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output alu_ready, lsu_ready, rf_we, rf_addr_rd, rf_data_rd
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the single regfile write port between the ALU (src0) and the load
// unit (src1). Loads win conflicts unless the ALU has already been denied
// MAX_WAIT consecutive cycles. The winner is registered and written the
// following cycle; writes to x0 complete the handshake but never assert rf_we.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus            writeback interface (slave side)
//   conflict_cnt   saturating count of cycles with both sources valid
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int XLEN     = rf_wb_arbiter_pkg::XLEN,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   rf_wb_arbiter_if.slave   bus,
   output logic [CNT_W-1:0] conflict_cnt
);

   logic              alu_gnt;
   logic              lsu_gnt;
   logic              force_alu;
   wb_src_e           winner;
   logic [ADDR_W-1:0] win_rd;
   logic [XLEN-1:0]   win_data;

   logic [3:0]        wait_cnt_d, wait_cnt_q;
   logic [CNT_W-1:0]  conflict_cnt_d, conflict_cnt_q;
   logic              rf_we_d, rf_we_q;
   logic [ADDR_W-1:0] rf_addr_d, rf_addr_q;
   logic [XLEN-1:0]   rf_data_d, rf_data_q;

   assign force_alu = (wait_cnt_q == 4'(MAX_WAIT));

   // Grants depend only on valids, hold and the starvation counter, so the
   // sources never see a ready that is a function of their own rd/data.
   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (!reset && !bus.wb_hold) begin
         if (bus.alu_valid && (!bus.lsu_valid || force_alu)) begin
            alu_gnt = 1'b1;
         end else if (bus.lsu_valid) begin
            lsu_gnt = 1'b1;
         end
      end
   end

   assign bus.alu_ready = alu_gnt;
   assign bus.lsu_ready = lsu_gnt;

   assign winner   = alu_gnt ? WB_SRC_ALU : WB_SRC_LSU;
   assign win_rd   = (winner == WB_SRC_ALU) ? bus.alu_rd   : bus.lsu_rd;
   assign win_data = (winner == WB_SRC_ALU) ? bus.alu_data : bus.lsu_data;

   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (alu_gnt || lsu_gnt) begin
         // x0 target: capture address/data anyway, just suppress the enable
         rf_we_d   = (win_rd != ADDR_W'(REG_ZERO));
         rf_addr_d = win_rd;
         rf_data_d = win_data;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!bus.wb_hold) begin
         if (!bus.alu_valid || alu_gnt) begin
            wait_cnt_d = '0;
         end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end
      end
   end

   // Counts contention independently of hold: it measures demand, not grants.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (bus.alu_valid && bus.lsu_valid && (conflict_cnt_q != '1)) begin
         conflict_cnt_d = conflict_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q     <= '0;
         conflict_cnt_q <= '0;
         rf_we_q        <= 1'b0;
         rf_addr_q      <= '0;
         rf_data_q      <= '0;
      end else begin
         wait_cnt_q     <= wait_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
         rf_we_q        <= rf_we_d;
         rf_addr_q      <= rf_addr_d;
         rf_data_q      <= rf_data_d;
      end
   end

   assign bus.rf_we      = rf_we_q;
   assign bus.rf_addr_rd = rf_addr_q;
   assign bus.rf_data_rd = rf_data_q;
   assign conflict_cnt   = conflict_cnt_q;

endmodule
